// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI host sequencer: FSM encoding,
// key-size byte values and the key_len -> key-byte-count decode.
package aes_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_TX_LOAD  = 3'd1,
    ST_TX_WAIT  = 3'd2,
    ST_RES_WAIT = 3'd3,
    ST_RX_LOAD  = 3'd4,
    ST_RX_WAIT  = 3'd5,
    ST_RESP     = 3'd6
  } state_e;

  localparam logic [7:0] SIZE_128        = 8'd16;
  localparam logic [7:0] SIZE_192        = 8'd24;
  localparam logic [7:0] SIZE_256        = 8'd32;
  localparam int         BLOCK_BYTES     = 16;
  localparam logic [1:0] KEY_LEN_ILLEGAL = 2'd3;

  // The illegal encoding is rejected before this is ever consulted.
  function automatic logic [7:0] key_bytes(input logic [1:0] key_len);
    case (key_len)
      2'd0:    key_bytes = SIZE_128;
      2'd1:    key_bytes = SIZE_192;
      default: key_bytes = SIZE_256;
    endcase
  endfunction

endpackage

// File: rtl/aes_tx_byte_sel.sv
// Picks the outgoing byte for a given transfer index: 16 block bytes MSB first,
// then the key-size byte K, then K key bytes from the MSB of the right-aligned key.
module aes_tx_byte_sel
  import aes_spi_pkg::*;
(
  input  logic [127:0] block_i,
  input  logic [255:0] key_i,
  input  logic [7:0]   k_i,
  input  logic [5:0]   byte_cnt_i,
  output logic [7:0]   byte_o
);

  logic [3:0] blk_idx;
  logic [5:0] key_ofs;
  logic [4:0] key_idx;

  assign blk_idx = 4'(BLOCK_BYTES - 1) - byte_cnt_i[3:0];
  assign key_ofs = byte_cnt_i - 6'(BLOCK_BYTES + 1);
  // Byte position counted from the LSB of key_i; the first key byte is byte K-1.
  assign key_idx = 5'(k_i[5:0] - 6'd1 - key_ofs);

  always_comb begin
    byte_o = 8'h00;
    if (byte_cnt_i < 6'(BLOCK_BYTES)) begin
      byte_o = block_i[{blk_idx, 3'b000} +: 8];
    end else if (byte_cnt_i == 6'(BLOCK_BYTES)) begin
      byte_o = k_i;
    end else begin
      byte_o = key_i[{key_idx, 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/aes_spi_host_seq.sv
// Host-side AES job sequencer: streams block, key size and key to the SPI master, then reads 16 result bytes back.
// Defining AES_HOST_TIMEOUT_EN adds a per-wait-state watchdog that ends the job with rsp_err.
module aes_spi_host_seq
  import aes_spi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [7:0]  DUMMY_BYTE     = 8'h00
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] block_in,
  input  logic [255:0] key_in,
  input  logic [1:0]   key_len,
  output logic         m_start,
  output logic [7:0]   m_data_in,
  input  logic [7:0]   m_data_out,
  input  logic         m_done,
  input  logic         m_busy,
  input  logic         slv_sending,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err
);

  state_e       state_q, state_d;
  logic [5:0]   byte_cnt_q, byte_cnt_d;
  logic [127:0] blk_q, blk_d;
  logic [255:0] key_q, key_d;
  logic [1:0]   klen_q, klen_d;
  logic         m_start_q, m_start_d;
  logic [7:0]   m_data_q, m_data_d;
  logic [127:0] sh_q, sh_d;
  logic [127:0] rsp_data_q, rsp_data_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         rsp_err_q, rsp_err_d;

  logic [7:0]   k_bytes;
  logic [5:0]   tx_last;
  logic [7:0]   tx_byte;
  logic         expired;

  assign k_bytes = key_bytes(klen_q);
  assign tx_last = 6'(BLOCK_BYTES) + k_bytes[5:0];

  aes_tx_byte_sel u_tx_sel (
    .block_i    (blk_q),
    .key_i      (key_q),
    .k_i        (k_bytes),
    .byte_cnt_i (byte_cnt_q),
    .byte_o     (tx_byte)
  );

`ifdef AES_HOST_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [WAIT_W-1:0] wait_q, wait_d;

  // Restarts on every state change, so each wait state gets the full budget.
  always_comb begin
    wait_d = '0;
    if (state_d == state_q &&
        (state_q == ST_TX_WAIT || state_q == ST_RX_WAIT || state_q == ST_RES_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign expired = (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q <= '0;
    end else begin
      wait_q <= wait_d;
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= '0;
      blk_q       <= '0;
      key_q       <= '0;
      klen_q      <= '0;
      m_start_q   <= 1'b0;
      m_data_q    <= '0;
      sh_q        <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      blk_q       <= blk_d;
      key_q       <= key_d;
      klen_q      <= klen_d;
      m_start_q   <= m_start_d;
      m_data_q    <= m_data_d;
      sh_q        <= sh_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // A completing m_done is checked before the watchdog so it wins a tie.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = (key_len == KEY_LEN_ILLEGAL) ? ST_RESP : ST_TX_LOAD;
        end
      end
      ST_TX_LOAD: begin
        if (!m_busy) state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (m_done) begin
          state_d = (byte_cnt_q == tx_last) ? ST_RES_WAIT : ST_TX_LOAD;
        end else if (expired) begin
          state_d = ST_RESP;
        end
      end
      ST_RES_WAIT: begin
        if (slv_sending) begin
          state_d = ST_RX_LOAD;
        end else if (expired) begin
          state_d = ST_RESP;
        end
      end
      ST_RX_LOAD: begin
        if (!m_busy) state_d = ST_RX_WAIT;
      end
      ST_RX_WAIT: begin
        if (m_done) begin
          state_d = (byte_cnt_q == 6'(BLOCK_BYTES - 1)) ? ST_RESP : ST_RX_LOAD;
        end else if (expired) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    blk_d       = blk_q;
    key_d       = key_q;
    klen_d      = klen_q;
    m_start_d   = 1'b0;
    m_data_d    = m_data_q;
    sh_d        = sh_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          blk_d      = block_in;
          key_d      = key_in;
          klen_d     = key_len;
          byte_cnt_d = '0;
          sh_d       = '0;
        end
      end
      ST_TX_LOAD: begin
        if (!m_busy) begin
          m_start_d = 1'b1;
          m_data_d  = tx_byte;
        end
      end
      ST_TX_WAIT: begin
        if (m_done) byte_cnt_d = (byte_cnt_q == tx_last) ? 6'd0 : byte_cnt_q + 6'd1;
      end
      ST_RX_LOAD: begin
        if (!m_busy) begin
          m_start_d = 1'b1;
          m_data_d  = DUMMY_BYTE;
        end
      end
      ST_RX_WAIT: begin
        if (m_done) begin
          sh_d       = {sh_q[119:0], m_data_out};
          byte_cnt_d = byte_cnt_q + 6'd1;
        end
      end
      ST_RESP: begin
        rsp_valid_d = !(rsp_valid_q && rsp_ready);
      end
      default: ;
    endcase
    // The only error-free way into RESP is the 16th result byte arriving.
    if (state_d == ST_RESP && state_q != ST_RESP) begin
      rsp_data_d = sh_d;
      rsp_err_d  = !(state_q == ST_RX_WAIT && m_done);
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign m_start   = m_start_q;
  assign m_data_in = m_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_aes_spi_host_seq.sv
// Bench for aes_spi_host_seq: table of AES jobs against a master/slave model,
// plus hand sequences for illegal key length, mid-job reset and the watchdog.
`timescale 1ns/1ps
module tb_aes_spi_host_seq;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [127:0] block_in = '0;
  logic [255:0] key_in = '0;
  logic [1:0]   key_len = '0;
  logic         m_start;
  logic [7:0]   m_data_in;
  logic [7:0]   m_data_out = '0;
  logic         m_done = 1'b0;
  logic         m_busy = 1'b0;
  logic         slv_sending = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_err;

  always #5 clk = ~clk;

`ifdef AES_HOST_TIMEOUT_EN
  localparam int unsigned TO_CYC = 64;
`else
  localparam int unsigned TO_CYC = 4096;
`endif

  aes_spi_host_seq #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .block_in    (block_in),
    .key_in      (key_in),
    .key_len     (key_len),
    .m_start     (m_start),
    .m_data_in   (m_data_in),
    .m_data_out  (m_data_out),
    .m_done      (m_done),
    .m_busy      (m_busy),
    .slv_sending (slv_sending),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err)
  );

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  typedef struct {
    logic [1:0]   klen;
    logic [255:0] key;
    int           k;
    logic [127:0] res;
  } vec_t;

  vec_t vecs[3];

  int n_tests = 0;
  int n_fail  = 0;

  // Master + slave model state
  int           exp_tx = 0;
  logic [127:0] exp_res = '0;
  bit           slv_en = 1'b1;
  bit           mdl_clr = 1'b0;
  int           nstart = 0;
  int           ndone = 0;
  int           busy_cnt = 0;
  int           sls_dly = 0;
  logic [127:0] rx_tmp;
  logic [7:0]   tx_log[$];

  // Each transfer takes a few cycles; result bytes are served once all command bytes went out.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (reset || mdl_clr) begin
      busy_cnt = 0; m_busy = 1'b0; ndone = 0; nstart = 0;
      slv_sending = 1'b0; sls_dly = 0; tx_log.delete();
    end else begin
      if (m_start) begin
        tx_log.push_back(m_data_in);
        nstart++;
        busy_cnt = 3;
        m_busy = 1'b1;
      end else if (busy_cnt != 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (ndone >= exp_tx) begin
            rx_tmp = exp_res << (8 * (ndone - exp_tx));
            m_data_out = rx_tmp[127:120];
          end else begin
            m_data_out = 8'hA5;
          end
          ndone++;
        end
      end
      if (slv_en && ndone >= exp_tx && !slv_sending) begin
        sls_dly++;
        if (sls_dly == 5) slv_sending = 1'b1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [255:0] key, input int k);
    logic [127:0] b;
    b = PT;
    if (i < 16) return b[(127 - 8*i) -: 8];
    else if (i == 16) return 8'(k);
    else if (i < 17 + k) return key[(8*(k - 1 - (i - 17))) +: 8];
    else return 8'h00;
  endfunction

  task automatic start_job(input int vi, input bit slave_on);
    exp_tx  = 17 + vecs[vi].k;
    exp_res = vecs[vi].res;
    slv_en  = slave_on;
    mdl_clr = 1'b1;
    tick();
    mdl_clr = 1'b0;
    block_in  = PT;
    key_in    = vecs[vi].key;
    key_len   = vecs[vi].klen;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic run_job(input int vi, input string tag);
    int n;
    int nbad;
    start_job(vi, 1'b1);
    n = 0;
    while (!rsp_valid && n < 3000) begin
      tick();
      n++;
    end
    check({tag, " rsp_valid seen"}, rsp_valid, 1);
    check({tag, " m_start count"}, nstart, exp_tx + 16);
    if (tx_log.size() > 16) check({tag, " key-size byte"}, tx_log[16], 8'(vecs[vi].k));
    else check({tag, " key-size byte present"}, tx_log.size(), 17);
    nbad = 0;
    for (int i = 0; i < tx_log.size(); i++) begin
      if (tx_log[i] !== exp_byte(i, vecs[vi].key, vecs[vi].k)) nbad++;
    end
    check({tag, " MOSI byte errors"}, nbad, 0);
    check({tag, " rsp_data"}, rsp_data, vecs[vi].res);
    check({tag, " rsp_err"}, rsp_err, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " rsp_valid drop"}, rsp_valid, 0);
    check({tag, " req_ready back"}, req_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL global time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int  n;
    bit  hold;

    vecs[0] = '{2'd2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 32,
                128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[1] = '{2'd0, 256'h000102030405060708090a0b0c0d0e0f, 16,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[2] = '{2'd1, 256'h000102030405060708090a0b0c0d0e0f1011121314151617, 24,
                128'hdda97ca4864cdfe06eaf70a0ec0d7191};

    tick();
    tick();
    check("reset req_ready", req_ready, 1);
    check("reset m_start", m_start, 0);
    check("reset m_data_in", m_data_in, 0);
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_data", rsp_data, 0);
    check("reset rsp_err", rsp_err, 0);
    reset = 1'b0;
    tick();

    for (int v = 0; v < 3; v++) begin
      run_job(v, $sformatf("job%0d", v));
    end

    // Reset after the 20th transfer of an AES-256 job
    start_job(0, 1'b1);
    n = 0;
    while (ndone < 20 && n < 2000) begin
      tick();
      n++;
    end
    check("midjob reached 20 transfers", ndone, 20);
    reset = 1'b1;
    tick();
    check("midjob reset req_ready", req_ready, 1);
    check("midjob reset m_start", m_start, 0);
    check("midjob reset m_data_in", m_data_in, 0);
    check("midjob reset rsp_valid", rsp_valid, 0);
    check("midjob reset rsp_data", rsp_data, 0);
    check("midjob reset rsp_err", rsp_err, 0);
    reset = 1'b0;
    tick();
    run_job(1, "after-reset");

`ifdef AES_HOST_TIMEOUT_EN
    // Slave never raises slv_sending: error lands 64 cycles after entering RES_WAIT
    start_job(1, 1'b0);
    n = 0;
    while (ndone < 33 && n < 2000) begin
      tick();
      n++;
    end
    check("timeout tx complete", ndone, 33);
    for (int i = 0; i < 64; i++) tick();
    check("timeout rsp_err before expiry", rsp_err, 0);
    tick();
    check("timeout rsp_err at expiry", rsp_err, 1);
    tick();
    check("timeout rsp_valid", rsp_valid, 1);
    check("timeout rsp_data partial", rsp_data, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("timeout rsp_valid drop", rsp_valid, 0);
`endif

    // Illegal key length: no transfers, error response two cycles after the request
    mdl_clr = 1'b1;
    tick();
    mdl_clr = 1'b0;
    key_len   = 2'd3;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check("illegal rsp_valid one cycle after", rsp_valid, 0);
    tick();
    check("illegal rsp_valid", rsp_valid, 1);
    check("illegal rsp_err", rsp_err, 1);
    check("illegal rsp_data", rsp_data, 0);
    hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rsp_valid !== 1'b1) hold = 1'b0;
    end
    check("illegal rsp_valid held", hold, 1);
    check("illegal m_start count", nstart, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("illegal rsp_valid drop", rsp_valid, 0);
    check("illegal req_ready back", req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
